fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the CPU controller. Maintains the program counter, issues reads to a fixed 1-cycle-latency instruction memory, and buffers returned words in a DEPTH-entry prefetch FIFO. It also holds the instruction register (IR) and drives the decoded fields (opcode, cond, register addresses, immediates) that the controller consumes. The controller pops the FIFO into IR with `load_ir` and redirects fetch with `load_pc` or `clear_pc`.

---
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: program counter, 1-cycle instruction-memory requests, DEPTH-entry prefetch FIFO, IR and field decode.
// Optional macro FETCH_HLT_STOP_EN: stop issuing requests once an HLT word enters the FIFO.
module fetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_rdata,
    input  logic        load_ir,
    input  logic        load_pc,
    input  logic        clear_pc,
    input  logic [31:0] pc_in,
    output logic        instr_valid,
    output logic [31:0] ir_pc,
    output logic [3:0]  cond,
    output logic [6:0]  opcode,
    output logic        en_status,
    output logic [3:0]  rn,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rm,
    output logic [1:0]  shift_op,
    output logic [31:0] shift_imme,
    output logic [31:0] imme_data,
    output logic        halted
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] OCC_LIMIT = DEPTH[CNT_W:0];
    localparam logic [6:0] OP_HLT = 7'b0000001;

    logic [31:0]      pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      fifo_word_q [DEPTH];
    logic [31:0]      fifo_pc_q   [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      ir_pc_q, ir_pc_d;
    logic             stop;

    logic             redirect;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;

`ifdef FETCH_HLT_STOP_EN
    logic halted_q, halted_d;
    assign stop = halted_q;
`else
    assign stop = 1'b0;
`endif

    assign redirect  = clear_pc | load_pc;
    // In-flight request reserves a slot so its response can never overflow the FIFO.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue     = rst_n && !stop && !redirect && (occupancy < OCC_LIMIT);
    // A halted stream drops the response that was already in flight.
    assign push      = inflight_q && !redirect && !stop;
    assign pop       = load_ir && (count_q != '0) && !redirect;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = issue;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;

        if (redirect) begin
            pc_d    = clear_pc ? '0 : pc_in;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                pc_d     = pc_q + 32'd4;
                req_pc_d = pc_q;
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d  = head_q + PTR_W'(1);
                ir_d    = fifo_word_q[head_q];
                ir_pc_d = fifo_pc_q[head_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef FETCH_HLT_STOP_EN
    always_comb begin
        halted_d = halted_q;
        if (redirect) begin
            halted_d = 1'b0;
        end else if (push && (imem_rdata[27:21] == OP_HLT)) begin
            halted_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
`ifdef FETCH_HLT_STOP_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
`ifdef FETCH_HLT_STOP_EN
            halted_q   <= halted_d;
`endif
        end
    end

    // Storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_word_q[tail_q] <= imem_rdata;
            fifo_pc_q[tail_q]   <= req_pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign imem_rd_en  = issue;
    assign instr_valid = (count_q != '0);
    assign ir_pc       = ir_pc_q;
    assign halted      = stop;

    assign cond        = ir_q[31:28];
    assign opcode      = ir_q[27:21];
    assign en_status   = ir_q[20];
    assign rn          = ir_q[19:16];
    assign rd          = ir_q[15:12];
    assign rs          = ir_q[11:8];
    assign shift_op    = ir_q[6:5];
    assign rm          = ir_q[3:0];
    assign shift_imme  = {27'd0, ir_q[11:7]};
    assign imme_data   = {20'd0, ir_q[11:0]};

endmodule
